// File: rtl/trace_pkg.sv
// Shared types for the trace capture block: record layout,
// serializer states and the word-select helper.
package trace_pkg;

  localparam logic [7:0] TRACE_HDR   = 8'hA5;
  localparam int         TRACE_WORDS = 6;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [7:0]  cycle;
    logic [31:0] instruction;
    logic [31:0] alua;
    logic [31:0] alub;
    logic [31:0] writedata;
    logic [31:0] readdatamem;
  } record_t;

  // a buffered slot also carries the drop count
  // that was pending when it was pushed
  typedef struct packed {
    logic [7:0] drop;
    record_t    rec;
  } entry_t;

  function automatic logic [31:0] rec_word(
    entry_t     e,
    logic [2:0] i
  );
    logic [31:0] w;
    case (i)
      3'd0:    w = {TRACE_HDR, e.drop,
                    8'h00, e.rec.cycle};
      3'd1:    w = e.rec.instruction;
      3'd2:    w = e.rec.alua;
      3'd3:    w = e.rec.alub;
      3'd4:    w = e.rec.writedata;
      default: w = e.rec.readdatamem;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer, DEPTH entries.
// Ports: push/din in, pop in, head/next_head out, full/empty/level out.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   head,
  output entry_t                   next_head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LV = (AW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_nxt;

  assign rd_nxt = rd_ptr + 1'b1;
  assign full   = (level == FULL_LV);
  assign empty  = (level == '0);
  assign head   = mem[rd_ptr];

  // head after a pop; with one entry left the only
  // candidate is the record being pushed this cycle
  assign next_head = (level > (AW+1)'(1)) ?
                     mem[rd_nxt] : din;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Samples core debug taps into a record buffer and streams 6-word records.
// Ports: clk/rst, capture_en/change_only, 5 taps, out_valid/ready/data, level, overflow.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   change_only,
  input  logic [31:0]            instruction,
  input  logic [31:0]            ALUa,
  input  logic [31:0]            ALUb,
  input  logic [31:0]            writeData,
  input  logic [31:0]            readDataMem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam logic [2:0] LAST = 3'(TRACE_WORDS-1);

  logic [7:0]   cyc;
  logic [7:0]   drop_cnt;
  logic [159:0] taps;
  logic [159:0] last_stored;
  logic         cap;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  entry_t       din;
  entry_t       head;
  entry_t       next_head;
  state_t       state;
  state_t       state_nxt;
  logic [2:0]   idx;
  logic [2:0]   idx_nxt;
  logic [31:0]  data_nxt;

  assign taps = {instruction, ALUa, ALUb,
                 writeData, readDataMem};
  assign din  = {drop_cnt, cyc, taps};

  assign cap  = capture_en &&
                (!change_only || taps != last_stored);
  assign pop  = (state == SEND) && out_ready &&
                (idx == LAST);
  assign push = cap && (!full || pop);

  assign out_valid = (state == SEND);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // out_data is loaded with the word the next
  // cycle will present, so it stays a flop output
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = out_data;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          data_nxt  = rec_word(head, 3'd0);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST) begin
            idx_nxt = '0;
            if (level > 1 || push) begin
              data_nxt = rec_word(next_head, 3'd0);
            end else begin
              state_nxt = IDLE;
              data_nxt  = '0;
            end
          end else begin
            idx_nxt  = idx + 3'd1;
            data_nxt = rec_word(head, idx + 3'd1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      out_data <= data_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc         <= '0;
      drop_cnt    <= '0;
      last_stored <= '0;
      overflow    <= 1'b0;
    end else begin
      cyc <= cyc + 8'd1;
      if (push) begin
        drop_cnt    <= '0;
        last_stored <= taps;
      end else if (cap) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: record queue reference
// model plus directed table and corner-case sequences.
module tb_trace_capture;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce  = 1'b0;
  logic         co  = 1'b0;
  logic         rdy = 1'b0;
  logic [159:0] taps = '0;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [4:0]   level;
  logic         overflow;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .capture_en  (ce),
    .change_only (co),
    .instruction (taps[159:128]),
    .ALUa        (taps[127:96]),
    .ALUb        (taps[95:64]),
    .writeData   (taps[63:32]),
    .readDataMem (taps[31:0]),
    .out_valid   (out_valid),
    .out_ready   (rdy),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow)
  );

  typedef logic [5:0][31:0] rec_t;
  rec_t         q[$];
  bit           sending;
  int           idx;
  int           mcyc;
  int           mdrop;
  bit           movf;
  logic [159:0] last;

  int total  = 0;
  int passed = 0;
  int dut_hs = 0;

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic [4:0]  lvl;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h want %08h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    sending = 0;
    idx     = 0;
    mcyc    = 0;
    mdrop   = 0;
    movf    = 0;
    last    = '0;
  endtask

  task automatic model_step();
    bit   hs, pop, capt, push, ne;
    rec_t r;
    hs   = sending && rdy;
    pop  = hs && idx == 5;
    capt = ce && (!co || taps != last);
    push = capt && (q.size() < DEPTH || pop);
    r[0] = {8'hA5, mdrop[7:0], 8'h00, mcyc[7:0]};
    r[1] = taps[159:128];
    r[2] = taps[127:96];
    r[3] = taps[95:64];
    r[4] = taps[63:32];
    r[5] = taps[31:0];
    ne   = q.size() > 0;
    if (capt && !push) begin
      movf = 1;
      if (mdrop < 255) mdrop++;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(r);
      mdrop = 0;
      last  = taps;
    end
    if (!sending) begin
      sending = ne;
      idx     = 0;
    end else if (hs) begin
      if (pop) begin
        idx     = 0;
        sending = q.size() > 0;
      end else begin
        idx++;
      end
    end
    mcyc++;
  endtask

  task automatic mcheck();
    chk("valid", 32'(out_valid), 32'(sending));
    if (sending && q.size() > 0)
      chk("data", out_data, q[0][idx]);
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(movf));
  endtask

  // called at a negedge with inputs set; returns
  // at the next negedge after checking outputs
  task automatic step();
    if (out_valid && rdy) dut_hs++;
    model_step();
    @(posedge clk);
    @(negedge clk);
    mcheck();
  endtask

  task automatic do_reset();
    ce  = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mcheck();
  endtask

  task automatic new_taps();
    taps = {$urandom, $urandom, $urandom,
            $urandom, $urandom};
  endtask

  initial begin
    bit seen;
    int guard;

    #2;
    do_reset();

    // single capture at cycle 3, table-checked
    tbl[0] = '{1'b1, 1'b0, 32'h0,        5'd1};
    tbl[1] = '{1'b1, 1'b1, 32'hA5000003, 5'd1};
    tbl[2] = '{1'b1, 1'b1, 32'h8C010004, 5'd1};
    tbl[3] = '{1'b1, 1'b1, 32'h00000004, 5'd1};
    tbl[4] = '{1'b1, 1'b1, 32'h00000000, 5'd1};
    tbl[5] = '{1'b1, 1'b1, 32'h00000000, 5'd1};
    tbl[6] = '{1'b1, 1'b1, 32'h00000007, 5'd1};
    tbl[7] = '{1'b1, 1'b0, 32'h0,        5'd0};
    taps = {32'h8C010004, 32'd4, 32'd0,
            32'd0, 32'd7};
    for (int k = 0; k < 14; k++) begin
      ce = (k == 3);
      if (k >= 4 && k < 12) begin
        rdy = tbl[k-4].rdy;
        chk("t1_valid", 32'(out_valid),
            32'(tbl[k-4].vld));
        if (tbl[k-4].vld)
          chk("t1_data", out_data, tbl[k-4].data);
        chk("t1_level", 32'(level),
            32'(tbl[k-4].lvl));
      end else begin
        rdy = 1'b1;
      end
      step();
    end

    // change_only with constant taps
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      dut_hs = 0;
      taps = (pass == 0) ?
             {5{32'h12345678}} : '0;
      co  = 1;
      rdy = 1;
      for (int k = 0; k < 20; k++) begin
        ce = (k < 10);
        step();
      end
      chk(pass == 0 ? "co_nonzero" : "co_zero",
          32'(dut_hs), pass == 0 ? 32'd6 : 32'd0);
      co = 0;
    end

    // overflow with stalled consumer
    do_reset();
    rdy = 0;
    for (int k = 0; k < 20; k++) begin
      ce = 1;
      new_taps();
      step();
    end
    ce = 0;
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    rdy = 1;
    for (int k = 0; k < 110; k++) step();
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      ce = (k == 0);
      if (out_valid && !seen) begin
        seen = 1;
        chk("ovf_dropcnt", 32'(out_data[23:16]),
            32'd4);
      end
      step();
    end
    chk("ovf_seen", 32'(seen), 32'd1);

    // counter wrap
    do_reset();
    rdy  = 1;
    seen = 0;
    new_taps();
    for (int k = 0; k < 300; k++) begin
      ce = (k == 258);
      if (out_valid && !seen) begin
        seen = 1;
        chk("wrap_cycle", 32'(out_data[7:0]),
            32'h02);
        chk("wrap_hdr", 32'(out_data[31:24]),
            32'hA5);
      end
      step();
    end
    chk("wrap_seen", 32'(seen), 32'd1);

    // reset in the middle of a record
    do_reset();
    rdy = 1;
    new_taps();
    ce = 1;
    step();
    ce = 0;
    guard = 0;
    while (!(sending && idx == 3) && guard < 20) begin
      step();
      guard++;
    end
    chk("mid_reach", 32'(guard < 20), 32'd1);
    do_reset();
    dut_hs = 0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_nowords", 32'(dut_hs), 32'd0);

    // random traffic and backpressure
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if (k < 400) begin
        ce  = ($urandom % 4) == 0;
        rdy = ($urandom % 3) != 0;
      end else begin
        ce  = ($urandom % 4) != 0;
        rdy = ($urandom % 2) == 0;
      end
      co = ($urandom % 3) == 0;
      if (($urandom % 3) != 0) new_taps();
      step();
    end
    ce  = 0;
    rdy = 1;
    for (int k = 0; k < 120; k++) step();
    chk("rand_empty", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

On-chip counterpart to the cycle-level console monitor of the MIPS_32 core. Each clock it samples the core's debug taps (instruction, ALU operands, write data, memory read data) and stamps each sample with an 8-bit cycle count. Samples go into a circular buffer and drain as 6-word records over a 32-bit valid/ready stream. It sits beside `top`, fed by the same signals the bench monitors, so traces can be pulled from silicon or FPGA instead of a simulator log.

## Interface
- `DEPTH`, 16: record slots in the buffer; power of two, at least 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `capture_en`  in  1: sample taps this cycle.
- `change_only`  in  1: when 1, sample only if any tap differs from the last stored record.
- `instruction`  in  32: instruction tap.
- `ALUa`  in  32: ALU operand A tap.
- `ALUb`  in  32: ALU operand B tap.
- `writeData`  in  32: write-data tap.
- `readDataMem`  in  32: memory read-data tap.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  32: record word stream.
- `level`  out  $clog2(DEPTH)+1: records currently buffered.
- `overflow`  out  1: sticky; a record was dropped since reset.

## Operation
- Cycle counter, 8 bits:
  - 0 on reset.
  - +1 every clock, wraps 255->0.
  - A stored record carries the counter value of its capture cycle.
- Capture condition is `capture_en && (!change_only || taps != last_stored)`.
  - `last_stored` resets to all-zero.
  - It updates only on a successful push.
- Record word order:
  - word0 = {8'hA5, drop_cnt[7:0], 8'h00, cycle[7:0]}
  - word1 = instruction
  - word2 = ALUa
  - word3 = ALUb
  - word4 = writeData
  - word5 = readDataMem
- Full buffer, capture with no pop the same cycle:
  - Record is dropped.
  - `drop_cnt` increments, saturating at 255.
  - `overflow` sets.
- `drop_cnt` goes into word0 of the next successful push, then clears in that same cycle.
- Push and pop in the same cycle while full: the push is accepted and `level` is unchanged.
- Serializer FSM:
  - IDLE: `out_valid`=0. When the buffer is non-empty, go to SEND with index 0.
  - SEND: `out_valid`=1 and `out_data` = word[index]. On `out_valid && out_ready`, index increments.
  - Index 5 accepted: pop the record. If the buffer is still non-empty (after that cycle's push), go to SEND index 0; otherwise go to IDLE.
- `out_data` and index stay stable while `out_ready`=0; no word is ever skipped or repeated.
- Reset mid-record discards the buffer and any partially sent record; no resume.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0.
  - Cycle counter 0, `drop_cnt` 0, FSM in IDLE.
- Push at edge N: `level` updates at N.
- Empty buffer: `out_valid` rises at edge N+1 with word0; minimum latency is 1 cycle.
- Back-to-back records: word0 of the next record is presented in the cycle after word5 is accepted. There are no idle gaps while data remains.
- With `out_ready` held at 1, one record drains per 6 cycles. Sustained capture faster than that overflows.
- `out_data` is registered, with no combinational path from `out_ready`.

## Structure
- Package `trace_pkg` holds:
  - header constant `TRACE_HDR` = 8'hA5;
  - `TRACE_WORDS` = 6;
  - the FSM state enum (IDLE, SEND);
  - the packed 168-bit record typedef (cycle + 5 taps).
- Sub-module `trace_fifo` (DEPTH x record):
  - pointer wrap, full/empty and level;
  - push with pop-when-full rule.
- The top level holds the cycle counter, capture filter, drop accounting and serializer.

## Test plan
- Capture, fully drained:
  - Stimulus: reset; `capture_en`=1 for exactly cycle 3 with instruction=32'h8C010004, ALUa=4, ALUb=0, writeData=0, readDataMem=7; `out_ready`=1.
  - Required: the stream emits A5000003, 8C010004, 4, 0, 0, 7, then `out_valid`=0.
- `change_only`=1 with constant taps for 10 cycles and `capture_en`=1:
  - Taps nonzero: exactly 1 record.
  - Taps all zero: 0 records, because `last_stored` resets to all-zero.
- Overflow:
  - Stimulus: DEPTH=16, `out_ready`=0, `capture_en`=1 for 20 cycles.
  - Required: `level`=16 and `overflow`=1. After draining, the next capture's word0 byte2 = 4.
- Backpressure: toggle `out_ready` randomly; every record arrives intact and in order, with no duplicated or lost words.
- Wrap:
  - Stimulus: run 300 cycles and capture at cycle 258.
  - Required: word0 low byte = 8'h02.
- Reset mid-record:
  - Stimulus: assert `rst` after word2 is accepted.
  - Required: `out_valid`=0 and `level`=0 immediately, with no further words.
